// File: rtl/systolic_feeder_4.sv
// Operand feeder for a 4x4 output-stationary systolic array: buffers A and B,
// then streams them skewed into the west/north edges. Optional FEEDER_WR_LOCK_EN blocks writes while busy.
module systolic_feeder_4 #(
    parameter int data_size    = 8,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic                 wr_sel,
    input  logic [3:0]           wr_addr,
    input  logic [data_size-1:0] wr_data,
    input  logic                 start,
    output logic                 busy,
    output logic                 arr_reset,
    output logic [data_size-1:0] a1,
    output logic [data_size-1:0] a2,
    output logic [data_size-1:0] a3,
    output logic [data_size-1:0] a4,
    output logic [data_size-1:0] b1,
    output logic [data_size-1:0] b2,
    output logic [data_size-1:0] b3,
    output logic [data_size-1:0] b4,
    output logic                 done,
    output logic                 wr_err
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } state_t;

    localparam logic [2:0] LAST_STEP  = 3'd6;
    localparam logic [3:0] LAST_DRAIN = 4'(DRAIN_CYCLES - 1);

    state_t               state, state_next;
    logic [2:0]           step, step_next;
    logic [3:0]           drain, drain_next;

    logic [data_size-1:0] mem_a [4][4];
    logic [data_size-1:0] mem_b [4][4];

    logic [data_size-1:0] a_q    [4];
    logic [data_size-1:0] b_q    [4];
    logic [data_size-1:0] a_next [4];
    logic [data_size-1:0] b_next [4];
    logic [2:0]           lag    [4];

    logic                 wr_accept;

    assign busy      = (state != IDLE);
    assign arr_reset = (state == CLEAR);
    assign done      = (state == DONE);

    assign a1 = a_q[0];
    assign a2 = a_q[1];
    assign a3 = a_q[2];
    assign a4 = a_q[3];
    assign b1 = b_q[0];
    assign b2 = b_q[1];
    assign b3 = b_q[2];
    assign b4 = b_q[3];

`ifdef FEEDER_WR_LOCK_EN
    logic wr_err_q;

    assign wr_accept = wr_en && !busy;
    assign wr_err    = wr_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_en && busy;
        end
    end
`else
    assign wr_accept = wr_en;
    assign wr_err    = 1'b0;
`endif

    // NOTE: every variable gets its default before the case, otherwise an
    // unassigned path infers a latch.
    always_comb begin
        state_next = state;
        step_next  = step;
        drain_next = drain;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                state_next = FEED;
                step_next  = '0;
            end
            FEED: begin
                if (step == LAST_STEP) begin
                    state_next = DRAIN;
                    step_next  = '0;
                    drain_next = '0;
                end else begin
                    step_next = step + 3'd1;
                end
            end
            DRAIN: begin
                if (drain == LAST_DRAIN) begin
                    state_next = DONE;
                    drain_next = '0;
                end else begin
                    drain_next = drain + 4'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Stream i lags by i steps; outside its 4-step window it feeds zero.
    // Values are looked up for the step being entered so the outputs can be registered.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lag[i]    = step_next - 3'(i);
            a_next[i] = '0;
            b_next[i] = '0;
            if (state_next == FEED && step_next >= 3'(i) && lag[i] <= 3'd3) begin
                a_next[i] = mem_a[i][lag[i][1:0]];
                b_next[i] = mem_b[lag[i][1:0]][i];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            step  <= '0;
            drain <= '0;
            // NOTE: the operand buffers are deliberately cleared on reset so a
            // run after reset streams zeros rather than stale operands.
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    mem_a[r][c] <= '0;
                    mem_b[r][c] <= '0;
                end
                a_q[r] <= '0;
                b_q[r] <= '0;
            end
        end else begin
            state <= state_next;
            step  <= step_next;
            drain <= drain_next;
            for (int i = 0; i < 4; i++) begin
                a_q[i] <= a_next[i];
                b_q[i] <= b_next[i];
            end
            if (wr_accept) begin
                if (wr_sel) begin
                    mem_b[wr_addr[3:2]][wr_addr[1:0]] <= wr_data;
                end else begin
                    mem_a[wr_addr[3:2]][wr_addr[1:0]] <= wr_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_feeder_4.sv
// Directed bench for systolic_feeder_4: skew timing, ignored restart, mid-run reset,
// write/start collision, write locking, and a behavioural 4x4 MAC array for the full path.
module tb_systolic_feeder_4;

    localparam int D  = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset, wr_en, wr_sel, start;
    logic [3:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy, arr_reset, done, wr_err;
    logic [DW-1:0] a1, a2, a3, a4, b1, b2, b3, b4;

    logic [DW-1:0] a_vec [4];
    logic [DW-1:0] b_vec [4];
    logic [DW-1:0] ea [4][4];
    logic [DW-1:0] eb [4][4];
    logic [DW-1:0] a1_log [32];
    logic [DW-1:0] a4_log [32];
    logic [DW-1:0] b1_log [32];

    int pa [4][4];
    int pb [4][4];
    int cacc [4][4];

    int checks = 0;
    int errors = 0;

    systolic_feeder_4 #(.data_size(DW), .DRAIN_CYCLES(D)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_addr(wr_addr), .wr_data(wr_data), .start(start), .busy(busy),
        .arr_reset(arr_reset), .a1(a1), .a2(a2), .a3(a3), .a4(a4),
        .b1(b1), .b2(b2), .b3(b3), .b4(b4), .done(done), .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    always_comb begin
        a_vec[0] = a1; a_vec[1] = a2; a_vec[2] = a3; a_vec[3] = a4;
        b_vec[0] = b1; b_vec[1] = b2; b_vec[2] = b3; b_vec[3] = b4;
    end

    // Output-stationary 4x4 MAC array attached to the feeder streams.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                automatic int ain = (j == 0) ? int'(a_vec[i]) : pa[i][j-1];
                automatic int bin = (i == 0) ? int'(b_vec[j]) : pb[i-1][j];
                pa[i][j]   <= ain;
                pb[i][j]   <= bin;
                cacc[i][j] <= arr_reset ? 0 : cacc[i][j] + ain * bin;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [DW-1:0] exp_a(input int i, input int k);
        if (k >= 0 && k <= 6 && k - i >= 0 && k - i <= 3) return ea[i][k-i];
        return '0;
    endfunction

    function automatic logic [DW-1:0] exp_b(input int j, input int k);
        if (k >= 0 && k <= 6 && k - j >= 0 && k - j <= 3) return eb[k-j][j];
        return '0;
    endfunction

    task automatic write_el(input bit sel, input int r, input int c, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = 4'(r * 4 + c);
        wr_data = d;
        tick();
        wr_en = 1'b0;
        if (sel) eb[r][c] = d;
        else     ea[r][c] = d;
    endtask

    // Start is sampled at edge N; on return the bench sits in cycle N+10+D (idle).
    task automatic do_run(input bit repeat_start);
        int dones = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("clear_arr_reset", arr_reset, 1);
        check("clear_busy", busy, 1);
        check("clear_a1", a1, 0);
        for (int c = 2; c <= 9 + D; c++) begin
            tick();
            start = 1'b0;
            a1_log[c] = a1;
            a4_log[c] = a4;
            b1_log[c] = b1;
            for (int i = 0; i < 4; i++) begin
                check($sformatf("a%0d_c%0d", i + 1, c), a_vec[i], exp_a(i, c - 2));
                check($sformatf("b%0d_c%0d", i + 1, c), b_vec[i], exp_b(i, c - 2));
            end
            check($sformatf("busy_c%0d", c), busy, 1);
            check($sformatf("arr_reset_c%0d", c), arr_reset, 0);
            check($sformatf("done_c%0d", c), done, 32'(c == 9 + D));
            if (done) dones++;
            if (repeat_start && c == 4) start = 1'b1;
        end
        tick();
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("done_pulses", dones, 1);
        tick();
        check("no_queued_run", busy, 0);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            tick();
            if (done) seen = 1'b1;
        end
        check("done_seen", seen, 1);
        tick();
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                ea[r][c] = '0;
                eb[r][c] = '0;
            end
        tick(); tick();
        reset = 1'b0;
        tick();
        check("rst_busy", busy, 0);
        check("rst_arr_reset", arr_reset, 0);
        check("rst_done", done, 0);
        check("rst_wr_err", wr_err, 0);
        check("rst_a1", a1, 0);
        check("rst_b4", b4, 0);

        // Ramp A and identity B; repeat start in cycle N+4 must be ignored.
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                write_el(1'b0, r, c, DW'(4 * r + c + 1));
                write_el(1'b1, r, c, (r == c) ? DW'(1) : DW'(0));
            end
        do_run(1'b1);
        check("a1_n2", a1_log[2], 8'd1);
        check("a1_n3", a1_log[3], 8'd2);
        check("a1_n4", a1_log[4], 8'd3);
        check("a1_n5", a1_log[5], 8'd4);
        check("a4_n4", a4_log[4], 8'd0);
        check("a4_n5", a4_log[5], 8'd13);
        check("b1_n2", b1_log[2], 8'd1);
        check("b1_n3", b1_log[3], 8'd0);
        check("b1_n5", b1_log[5], 8'd0);

        // Full path with the MAC array: all-2 operands give 16 in every cell.
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                write_el(1'b0, r, c, 8'd2);
                write_el(1'b1, r, c, 8'd2);
            end
        do_run(1'b0);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                check($sformatf("c%0d%0d", i, j), cacc[i][j], 16);

        // Reset asserted in cycle N+5 aborts the run and clears the buffers.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_arr_reset", arr_reset, 0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("abort_a%0d", i + 1), a_vec[i], 0);
            check($sformatf("abort_b%0d", i + 1), b_vec[i], 0);
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                ea[r][c] = '0;
                eb[r][c] = '0;
            end
        begin
            int late_dones = 0;
            for (int n = 0; n < 12; n++) begin
                tick();
                if (done || busy) late_dones++;
            end
            check("abort_no_done", late_dones, 0);
        end
        do_run(1'b0);

        // Write during a run, then a write colliding with start in IDLE.
        write_el(1'b0, 0, 0, 8'h05);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 8'hFF;
        tick();
        wr_en = 1'b0;
`ifdef FEEDER_WR_LOCK_EN
        check("lock_wr_err", wr_err, 1);
`else
        check("open_wr_err", wr_err, 0);
        ea[0][0] = 8'hFF;
`endif
        tick();
        check("wr_err_one_cycle", wr_err, 0);
        wait_done();
        start = 1'b1;
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd1; wr_data = 8'h42;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        tick();
`ifdef FEEDER_WR_LOCK_EN
        check("rerun_a00", a1, 8'h05);
`else
        check("rerun_a00", a1, 8'hFF);
`endif
        tick();
        check("collide_a01", a1, 8'h42);
        wait_done();
        check("final_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
